// File: rtl/dpll_phase_filter.sv
// Phase detector and random-walk loop filter for a digital PLL: compares data edges against the
// local I/Q bit clocks, filters early/late decisions into DCO add/deduct requests, tracks lock.
module dpll_phase_filter #(
  parameter int unsigned K_MAX     = 8,
  parameter int unsigned EDGE_MODE = 0,
  parameter int unsigned LOCK_CNT  = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable_i,
  input  logic data_i,
  input  logic clk_i_i,
  input  logic clk_q_i,
  output logic pd_bef_o,
  output logic pd_aft_o,
  output logic add_o,
  output logic ded_o,
  output logic lock_o
);

  localparam int unsigned CntW = $clog2(K_MAX) + 2;
  localparam logic signed [CntW-1:0] KPos   = CntW'(K_MAX);
  localparam logic signed [CntW-1:0] KNeg   = -KPos;
  localparam logic signed [CntW-1:0] CntOne = CntW'(1);
  localparam logic [9:0]             LcMax  = 10'(LOCK_CNT);

  typedef enum logic [0:0] {StUnlock, StLock} state_e;

  logic                   s1_q, s2_q, s3_q;
  logic                   data_edge;
  logic signed [CntW-1:0] cnt_q, cnt_d, cnt_inc, cnt_dec;
  logic                   add_d, ded_d;
  logic [9:0]             lc_q, lc_d;
  state_e                 state_q, state_d;

  always_comb begin
    data_edge = s2_q ^ s3_q;
    if (EDGE_MODE == 1) begin
      data_edge = s2_q & ~s3_q;
    end else if (EDGE_MODE == 2) begin
      data_edge = ~s2_q & s3_q;
    end
  end

  // Random walk: a full run of K_MAX same-direction decisions triggers one DCO correction.
  always_comb begin
    cnt_d   = cnt_q;
    add_d   = 1'b0;
    ded_d   = 1'b0;
    cnt_inc = cnt_q + CntOne;
    cnt_dec = cnt_q - CntOne;
    if (enable_i) begin
      if (pd_bef_o) begin
        if (cnt_inc == KPos) begin
          cnt_d = '0;
          ded_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end else if (pd_aft_o) begin
        if (cnt_dec == KNeg) begin
          cnt_d = '0;
          add_d = 1'b1;
        end else begin
          cnt_d = cnt_dec;
        end
      end
    end
  end

  always_comb begin
    lc_d    = lc_q;
    state_d = state_q;
    if (add_d || ded_d) begin
      lc_d    = '0;
      state_d = StUnlock;
    end else if (enable_i && (pd_bef_o || pd_aft_o)) begin
      if (lc_q != LcMax) begin
        lc_d = lc_q + 10'd1;
      end
      if (lc_d == LcMax) begin
        state_d = StLock;
      end
    end
  end

  assign lock_o = (state_q == StLock);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
      pd_bef_o <= 1'b0;
      pd_aft_o <= 1'b0;
      add_o    <= 1'b0;
      ded_o    <= 1'b0;
      cnt_q    <= '0;
      lc_q     <= '0;
      state_q  <= StUnlock;
    end else begin
      s1_q     <= data_i;
      s2_q     <= s1_q;
      s3_q     <= s2_q;
      // In-phase clock wins so early and late never assert together.
      pd_bef_o <= data_edge & clk_i_i & enable_i;
      pd_aft_o <= data_edge & clk_q_i & ~clk_i_i & enable_i;
      add_o    <= add_d;
      ded_o    <= ded_d;
      cnt_q    <= cnt_d;
      lc_q     <= lc_d;
      state_q  <= state_d;
    end
  end

endmodule

// File: tb/tb_dpll_phase_filter.sv
// Scoreboard bench for dpll_phase_filter: stimulus queues expected output events with their
// cycle stamps, a negedge monitor pops and compares every event the DUT presents.
module tb_dpll_phase_filter;

  typedef struct {
    int         cyc;
    logic [4:0] vec;  // {pd_bef, pd_aft, add, ded, lock}
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b1;
  logic data = 1'b0;
  logic data_r = 1'b0;
  logic ph_i = 1'b0;
  logic ph_q = 1'b0;
  logic pd_bef, pd_aft, add, ded, lock;
  logic r_bef, r_aft, r_add, r_ded, r_lock;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   r_cnt = 0;
  int   r_cyc = 0;
  bit   exp_lock = 1'b0;
  logic lock_prev = 1'b0;
  logic [4:0] mon_vec;
  ev_t  mon_ev;
  ev_t  sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dpll_phase_filter #(.K_MAX(4), .EDGE_MODE(0), .LOCK_CNT(16)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .data_i(data), .clk_i_i(ph_i), .clk_q_i(ph_q),
    .pd_bef_o(pd_bef), .pd_aft_o(pd_aft), .add_o(add), .ded_o(ded), .lock_o(lock)
  );

  dpll_phase_filter #(.K_MAX(4), .EDGE_MODE(1), .LOCK_CNT(16)) dut_r (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .data_i(data_r), .clk_i_i(ph_i), .clk_q_i(ph_q),
    .pd_bef_o(r_bef), .pd_aft_o(r_aft), .add_o(r_add), .ded_o(r_ded), .lock_o(r_lock)
  );

  always @(negedge clk) begin
    mon_vec = {pd_bef, pd_aft, add, ded, lock};
    if ((|mon_vec[4:1]) || (lock !== lock_prev)) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event cyc=%0d got=%b required=none", cyc, mon_vec);
      end else begin
        mon_ev = sb.pop_front();
        if (mon_ev.cyc != cyc || mon_ev.vec !== mon_vec) begin
          failures++;
          $display("FAIL event got cyc=%0d vec=%b required cyc=%0d vec=%b",
                   cyc, mon_vec, mon_ev.cyc, mon_ev.vec);
        end
      end
    end
    lock_prev = lock;
    if (r_bef || r_aft) begin
      r_cnt++;
      r_cyc = cyc;
    end
  end

  function automatic void push(input int c, input logic [4:0] v);
    ev_t e;
    e.cyc = c;
    e.vec = v;
    sb.push_back(e);
  endfunction

  task automatic check(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  // One data transition with the phase clocks set for an early (bef=1) or late decision.
  task automatic do_edge(input bit bef, input bit exp_add, input bit exp_ded, input bit lock_after);
    int t;
    @(posedge clk); #1;
    ph_i = bef;
    ph_q = ~bef;
    data = ~data;
    t = cyc;
    push(t + 3, {bef, ~bef, 2'b00, exp_lock});
    if (exp_add || exp_ded || (lock_after != exp_lock)) begin
      push(t + 4, {2'b00, exp_add, exp_ded, lock_after});
    end
    exp_lock = lock_after;
    repeat (6) @(posedge clk);
  endtask

  function automatic int cnt_now();
    return int'($signed(dut.cnt_q));
  endfunction

  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", int'({pd_bef, pd_aft, add, ded, lock}), 0);
    check("reset_cnt", cnt_now(), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    do_edge(1'b1, 1'b0, 1'b0, 1'b0);
    #1 check("cnt_after_bef", cnt_now(), 1);
    do_edge(1'b0, 1'b0, 1'b0, 1'b0);
    #1 check("cnt_back_to_zero", cnt_now(), 0);

    for (int i = 0; i < 3; i++) begin
      do_edge(1'b0, 1'b0, 1'b0, 1'b0);
      #1 check("cnt_aft_walk", cnt_now(), -(i + 1));
    end
    do_edge(1'b0, 1'b1, 1'b0, 1'b0);
    #1 check("cnt_after_add", cnt_now(), 0);

    // Alternating decisions never correct; lc reaches 16 on the 16th edge.
    for (int i = 0; i < 20; i++) begin
      do_edge(i % 2 == 0, 1'b0, 1'b0, i >= 15);
    end
    #1 check("cnt_after_alternate", cnt_now(), 0);
    check("lock_after_alternate", int'(lock), 1);

    for (int i = 0; i < 3; i++) begin
      do_edge(1'b1, 1'b0, 1'b0, 1'b1);
    end
    #1 check("cnt_bef_walk", cnt_now(), 3);
    do_edge(1'b1, 1'b0, 1'b1, 1'b0);
    #1 check("cnt_after_ded", cnt_now(), 0);
    check("lc_after_ded", int'(dut.lc_q), 0);

    // Disabled: edge must be ignored and state held.
    @(posedge clk); #1;
    enable = 1'b0;
    ph_i = 1'b1;
    ph_q = 1'b0;
    data = ~data;
    repeat (6) @(posedge clk);
    #1 check("cnt_held_disabled", cnt_now(), 0);
    enable = 1'b1;
    repeat (3) @(posedge clk);

    for (int i = 0; i < 3; i++) begin
      do_edge(1'b1, 1'b0, 1'b0, 1'b0);
    end
    #1 check("cnt_before_reset", cnt_now(), 3);
    check("lc_before_reset", int'(dut.lc_q), 3);

    // Reset lands while pd_bef is high and a deduct is about to fire.
    @(posedge clk); #1;
    ph_i = 1'b1;
    ph_q = 1'b0;
    data = ~data;
    t = cyc;
    push(t + 3, 5'b10000);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    data = 1'b0;
    @(posedge clk);
    #1 check("midrun_reset_outputs", int'({pd_bef, pd_aft, add, ded, lock}), 0);
    check("midrun_reset_cnt", cnt_now(), 0);
    check("midrun_reset_lc", int'(dut.lc_q), 0);
    ph_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);

    // Rising-only instance: 0->1->0 gives a single pulse, three cycles after the rise.
    #1 r_cnt = 0;
    ph_i = 1'b1;
    ph_q = 1'b0;
    data_r = 1'b1;
    t = cyc;
    repeat (6) @(posedge clk);
    #1 data_r = 1'b0;
    repeat (6) @(posedge clk);
    #1 check("mode1_pulse_count", r_cnt, 1);
    check("mode1_pulse_cycle", r_cyc, t + 3);

    repeat (4) @(posedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
